program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Autonomous instruction feeder for the 9-bit base processor: fetches instruction words from a synchronous program ROM and drives the processor's run/din inputs.
- Waits for the processor's done, then advances the program counter.
- Handles the two-word mvi format (opcode 001 followed by an immediate word), a HALT opcode (111), a done-watchdog, and start/stop control from the top level.

Parameters:
- ADDR_W, 5, program ROM address width; pc wraps modulo 2^ADDR_W.
- DATA_W, 9, instruction/immediate width; must match the processor din.
- TIMEOUT, 16, maximum EXEC cycles without done before err_timeout (≥2).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-high reset (asserted = 1).
- start  in  1  one-cycle pulse: begin/resume execution.
- stop  in  1  one-cycle pulse: request stop after current instruction.
- rom_addr  out  ADDR_W  program ROM read address.
- rom_rd  out  1  ROM read strobe; rom_data valid the following cycle.
- rom_data  in  DATA_W  ROM read data.
- done  in  1  processor instruction-complete flag.
- run  out  1  processor run.
- din  out  DATA_W  processor data input (instruction or immediate).
- busy  out  1  high in any state except IDLE, HALT, ERROR.
- halted  out  1  HALT opcode reached.
- err_timeout  out  1  watchdog fired.
- pc  out  ADDR_W  address of the current/next instruction.
- instr_cnt  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (resetn=1 at an edge, any state including mid-EXEC):
  - state=IDLE; all outputs 0; internal ir_q, imm_q, watchdog and stop_pending cleared.
  - Processor is reset separately by the same line.
- States: IDLE, FETCH, WAIT_I, FETCH_IMM, WAIT_D, ISSUE, EXEC, HALT, ERROR. All outputs are registered.
- IDLE: run=0.
  - start → FETCH, resuming at the current pc.
- FETCH: rom_rd=1, rom_addr=pc → WAIT_I.
- WAIT_I: ir_q<=rom_data.
  - opcode (bits 8:6) 111 → HALT, halted=1.
  - opcode 001 → FETCH_IMM.
  - otherwise → ISSUE.
- FETCH_IMM: rom_rd=1, rom_addr=pc+1 (mod 2^ADDR_W) → WAIT_D.
- WAIT_D: imm_q<=rom_data → ISSUE.
- ISSUE (exactly 1 cycle): run=1, din=ir_q; done ignored → EXEC, watchdog=0.
- EXEC:
  - run=1; din=imm_q if opcode 001, else ir_q; watchdog increments each cycle.
  - done=1 in any EXEC cycle, including the first:
    - pc <= pc+2 if mvi, else pc+1 (wrap);
    - instr_cnt++ (saturates at all-ones);
    - → IDLE if stop_pending (then cleared), else → FETCH.
    - run drops to 0 in the following cycle.
  - watchdog reaches TIMEOUT with no done → ERROR: err_timeout=1, run=0, pc unchanged.
  - done and timeout in the same cycle: done wins.
- stop:
  - In ISSUE/EXEC: sets stop_pending; the instruction finishes normally.
  - In FETCH/WAIT_I/FETCH_IMM/WAIT_D: → IDLE next cycle, pc unchanged; a partially fetched mvi is refetched on resume.
  - Ignored in IDLE/HALT/ERROR.
- HALT/ERROR:
  - run=0, rom_rd=0; flag held.
  - start clears halted/err_timeout, sets pc=0 → FETCH; instr_cnt is not cleared.
- Simultaneous start and stop: stop has priority in active states; start has priority in IDLE/HALT/ERROR.
- Unlisted opcodes (100–110) are issued like mv; the sequencer does not validate them.

Test Plan:
- Reset: hold resetn=1 for 2 cycles with start=1 → run=0, rom_rd=0, pc=0, busy=0, instr_cnt=0, all flags 0.
- mv then HALT:
  - Stimulus: ROM[0]=9'b000_001_000, ROM[1]=9'b111_000_000, processor model asserts done in the first EXEC cycle, start pulse.
  - Expected: rom_rd at cycle 1; run high exactly 2 cycles with din=0x008; pc=1; halted=1, busy=0, instr_cnt=1.
- mvi r2,#5:
  - Stimulus: ROM[0]=9'b001_010_000, ROM[1]=9'd5.
  - Expected: rom_addr 0 then 1; din=0x050 in ISSUE, 0x005 in EXEC; pc=2 after done.
- Watchdog: TIMEOUT=8, done held 0 → err_timeout=1 and run=0 exactly 8 cycles after EXEC entry, pc unchanged; start → flag clears, rom_addr=0.
- Stop mid-instruction:
  - Stimulus: add program, stop pulsed during EXEC, done 2 cycles later.
  - Expected: instr_cnt increments, pc advances, no further rom_rd, state IDLE; next start fetches the following address.
  - Second case: stop during WAIT_D → IDLE, pc unchanged, mvi refetched on start.
- Wrap and reset:
  - ADDR_W=2, mvi at address 3 → immediate read from address 0, pc wraps to 1.
  - resetn asserted mid-EXEC → run=0 next cycle, pc=0.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: fetches instruction words from a synchronous program ROM
// and feeds them to the 9-bit processor (run/din). It handles two-word mvi, the
// HALT opcode, a done watchdog and start/stop requests from the top level.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | parked; start resumes fetching at the current pc
// FETCH     | rom_rd asserted for the instruction word at pc
// WAIT_I    | instruction word returns; decode HALT / mvi / other
// FETCH_IMM | rom_rd asserted for the mvi immediate at pc+1
// WAIT_D    | immediate word returns into imm_q
// ISSUE     | run=1, din=instruction word; done is ignored here
// EXEC      | run=1, din=immediate (mvi) or instruction; wait for done
// HALT      | HALT opcode reached; start restarts from address 0
// ERROR     | done watchdog expired; start restarts from address 0

module program_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 9,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              done,
  output logic              run,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              halted,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instr_cnt
);

  // Watchdog is a down-counter loaded at ISSUE; reaching zero in EXEC without
  // done means TIMEOUT EXEC cycles have elapsed.
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_WAIT_I    = 4'd2,
    S_FETCH_IMM = 4'd3,
    S_WAIT_D    = 4'd4,
    S_ISSUE     = 4'd5,
    S_EXEC      = 4'd6,
    S_HALT      = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] imm_q;
  logic [WD_W-1:0]   wdog_q;
  logic              stop_pending;

  logic              ir_mvi;
  logic [ADDR_W-1:0] pc_inc1;
  logic [ADDR_W-1:0] pc_next;
  logic [CNT_W-1:0]  cnt_next;

  // Decode of the held instruction and the retire-time pc/counter updates.
  assign ir_mvi   = (ir_q[8:6] == OP_MVI);
  assign pc_inc1  = pc + ADDR_W'(1);
  assign pc_next  = ir_mvi ? (pc + ADDR_W'(2)) : pc_inc1;
  assign cnt_next = (instr_cnt == {CNT_W{1'b1}}) ? instr_cnt : (instr_cnt + CNT_W'(1));

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state        <= S_IDLE;
      rom_addr     <= '0;
      rom_rd       <= 1'b0;
      run          <= 1'b0;
      din          <= '0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      err_timeout  <= 1'b0;
      pc           <= '0;
      instr_cnt    <= '0;
      ir_q         <= '0;
      imm_q        <= '0;
      wdog_q       <= '0;
      stop_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            rom_rd   <= 1'b1;
            rom_addr <= pc;
            busy     <= 1'b1;
          end
        end

        S_FETCH: begin
          rom_rd <= 1'b0;
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_WAIT_I;
          end
        end

        S_WAIT_I: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            ir_q <= rom_data;
            if (rom_data[8:6] == OP_HALT) begin
              state  <= S_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else if (rom_data[8:6] == OP_MVI) begin
              state    <= S_FETCH_IMM;
              rom_rd   <= 1'b1;
              rom_addr <= pc_inc1;
            end else begin
              state <= S_ISSUE;
              run   <= 1'b1;
              din   <= rom_data;
            end
          end
        end

        S_FETCH_IMM: begin
          rom_rd <= 1'b0;
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_WAIT_D;
          end
        end

        S_WAIT_D: begin
          if (stop) begin
            // The instruction word is refetched on resume, so nothing to keep.
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            imm_q <= rom_data;
            state <= S_ISSUE;
            run   <= 1'b1;
            din   <= ir_q;
          end
        end

        S_ISSUE: begin
          state  <= S_EXEC;
          wdog_q <= WD_LOAD;
          din    <= ir_mvi ? imm_q : ir_q;
          if (stop) stop_pending <= 1'b1;
        end

        S_EXEC: begin
          if (done) begin
            // done beats a watchdog expiry in the same cycle.
            pc           <= pc_next;
            instr_cnt    <= cnt_next;
            run          <= 1'b0;
            stop_pending <= 1'b0;
            if (stop_pending || stop) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= S_FETCH;
              rom_rd   <= 1'b1;
              rom_addr <= pc_next;
            end
          end else if (wdog_q == '0) begin
            state        <= S_ERROR;
            err_timeout  <= 1'b1;
            run          <= 1'b0;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
          end else begin
            wdog_q <= wdog_q - WD_W'(1);
            if (stop) stop_pending <= 1'b1;
          end
        end

        S_HALT, S_ERROR: begin
          if (start) begin
            state       <= S_FETCH;
            halted      <= 1'b0;
            err_timeout <= 1'b0;
            pc          <= '0;
            rom_rd      <= 1'b1;
            rom_addr    <= '0;
            busy        <= 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          run    <= 1'b0;
          rom_rd <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: ROM and processor models, directed scenarios
// with cycle-level checks, then randomized programs against an
// instruction-level reference model.

module tb_program_sequencer;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 9;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              resetn;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [DATA_W-1:0] rom_data;
  logic              done;
  logic              run;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              halted;
  logic              err_timeout;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  instr_cnt;

  program_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .done(done), .run(run), .din(din), .busy(busy), .halted(halted),
    .err_timeout(err_timeout), .pc(pc), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]        rom [DEPTH];
  int                n_checks = 0;
  int                n_pass = 0;

  // processor model / monitor state
  int                run_len = 0;
  logic              run_prev = 1'b0;
  logic [8:0]        issue_w = '0;
  int                cur_lat = 0;
  int                issue_idx = 0;
  int                run_hi_cnt = 0;
  logic [17:0]       iss_q [$];
  logic [ADDR_W-1:0] rd_q [$];
  int                lats [64];
  bit                use_arr = 1'b0;
  bit                spur_en = 1'b0;
  int                fixed_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return halted === 1'b1;
      1: return err_timeout === 1'b1;
      2: return run === 1'b1;
      4: return (rom_rd === 1'b1) && (rom_addr === 3'd1);
      5: return (halted === 1'b1) || (err_timeout === 1'b1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag);
    int n;
    n = 0;
    while (!cond(sel) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(cond(sel)), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Synchronous ROM: address captured at the edge, data valid the next cycle.
  initial begin : rom_model
    logic              r;
    logic [ADDR_W-1:0] a;
    rom_data = '0;
    forever begin
      @(negedge clk);
      r = (rom_rd === 1'b1);
      a = rom_addr;
      @(posedge clk);
      #1;
      if (r) rom_data = rom[a];
    end
  end

  // Processor model and issue monitor: done arrives `lat` cycles into EXEC.
  initial begin : proc_model
    done = 1'b0;
    forever begin
      @(negedge clk);
      if (rom_rd === 1'b1) rd_q.push_back(rom_addr);
      if (run === 1'b1) begin
        run_hi_cnt++;
        if (!run_prev) begin
          issue_w = din;
          cur_lat = use_arr ? lats[issue_idx % 64] : fixed_lat;
          issue_idx++;
          run_len = 1;
        end else begin
          run_len++;
          if (run_len == 2) iss_q.push_back({issue_w, din});
        end
      end else begin
        run_len = 0;
      end
      run_prev = (run === 1'b1);
      if (run_len == 1)
        done = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      else if (run_len >= 2 && cur_lat >= 0 && run_len == cur_lat + 2)
        done = 1'b1;
      else
        done = 1'b0;
    end
  end

  initial begin : global_guard
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int          exp_cnt;
    int          n;
    int          nrd;
    int          k;
    int          p;
    bit          exp_halt;
    bit          exp_err;
    bit          mvi;
    int          steps;
    logic [8:0]  w;
    logic [8:0]  e;
    logic [17:0] exp_q [$];

    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    for (int i = 0; i < 64; i++) lats[i] = 0;
    exp_cnt = 0;

    // reset held with start asserted
    resetn = 1'b1;
    start  = 1'b1;
    stop   = 1'b0;
    tick();
    tick();
    chk("rst_run", 32'(run), 0);
    chk("rst_rom_rd", 32'(rom_rd), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(err_timeout), 0);
    resetn = 1'b0;
    start  = 1'b0;
    tick();

    // mv then HALT
    rom[0] = 9'b000_001_000;
    rom[1] = 9'b111_000_000;
    fixed_lat = 0;
    run_hi_cnt = 0;
    iss_q.delete();
    pulse_start();
    chk("mv_rd_cycle1", 32'(rom_rd), 1);
    chk("mv_addr0", 32'(rom_addr), 0);
    wait_for(0, 60, "mv_reach_halt");
    exp_cnt = 1;
    chk("mv_run_cycles", 32'(run_hi_cnt), 2);
    chk("mv_issue_count", 32'(iss_q.size()), 1);
    chk("mv_din", (iss_q.size() > 0) ? 32'(iss_q[0]) : 32'hdead, {9'h008, 9'h008});
    chk("mv_pc", 32'(pc), 1);
    chk("mv_busy", 32'(busy), 0);
    chk("mv_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // mvi r2,#5
    rom[0] = 9'b001_010_000;
    rom[1] = 9'd5;
    rom[2] = 9'b111_000_000;
    iss_q.delete();
    rd_q.delete();
    pulse_start();
    chk("mvi_halt_cleared", 32'(halted), 0);
    wait_for(0, 60, "mvi_reach_halt");
    exp_cnt = 2;
    chk("mvi_rd0", (rd_q.size() > 1) ? 32'(rd_q[0]) : 32'hdead, 0);
    chk("mvi_rd1", (rd_q.size() > 1) ? 32'(rd_q[1]) : 32'hdead, 1);
    chk("mvi_din", (iss_q.size() > 0) ? 32'(iss_q[0]) : 32'hdead, {9'h050, 9'h005});
    chk("mvi_pc", 32'(pc), 2);
    chk("mvi_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // watchdog
    rom[0] = 9'b000_001_000;
    rom[1] = 9'b111_000_000;
    fixed_lat = -1;
    pulse_start();
    wait_for(2, 20, "wd_issue");
    n = 0;
    while (err_timeout !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("wd_cycles_after_issue", 32'(n), 32'(TIMEOUT + 1));
    chk("wd_err", 32'(err_timeout), 1);
    chk("wd_run", 32'(run), 0);
    chk("wd_pc", 32'(pc), 0);
    chk("wd_busy", 32'(busy), 0);
    chk("wd_cnt", 32'(instr_cnt), 32'(exp_cnt));
    fixed_lat = 0;
    pulse_start();
    chk("wd_err_cleared", 32'(err_timeout), 0);
    chk("wd_restart_addr", 32'(rom_addr), 0);
    chk("wd_restart_rd", 32'(rom_rd), 1);
    wait_for(0, 60, "wd_reach_halt");
    exp_cnt = 3;
    chk("wd_after_pc", 32'(pc), 1);
    chk("wd_after_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // stop during EXEC, done two cycles later
    rom[0] = 9'b010_001_010;
    rom[1] = 9'b000_010_001;
    rom[2] = 9'b111_000_000;
    fixed_lat = 2;
    pulse_start();
    wait_for(2, 20, "stx_issue");
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    nrd = rd_q.size();
    for (int i = 0; i < 6; i++) tick();
    exp_cnt = 4;
    chk("stx_busy", 32'(busy), 0);
    chk("stx_run", 32'(run), 0);
    chk("stx_halted", 32'(halted), 0);
    chk("stx_pc", 32'(pc), 1);
    chk("stx_cnt", 32'(instr_cnt), 32'(exp_cnt));
    chk("stx_no_read", 32'(rd_q.size()), 32'(nrd));
    pulse_start();
    chk("stx_resume_rd", 32'(rom_rd), 1);
    chk("stx_resume_addr", 32'(rom_addr), 1);
    wait_for(0, 60, "stx_reach_halt");
    exp_cnt = 5;
    chk("stx_final_pc", 32'(pc), 2);
    chk("stx_final_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // stop during WAIT_D, mvi refetched
    rom[0] = 9'b001_011_000;
    rom[1] = 9'h0AA;
    rom[2] = 9'b111_000_000;
    fixed_lat = 0;
    iss_q.delete();
    pulse_start();
    wait_for(4, 20, "std_fetch_imm");
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("std_busy", 32'(busy), 0);
    chk("std_run", 32'(run), 0);
    chk("std_pc", 32'(pc), 0);
    chk("std_no_issue", 32'(iss_q.size()), 0);
    rd_q.delete();
    pulse_start();
    chk("std_refetch_addr", 32'(rom_addr), 0);
    wait_for(0, 60, "std_reach_halt");
    exp_cnt = 6;
    chk("std_imm_read", (rd_q.size() > 1) ? 32'(rd_q[1]) : 32'hdead, 1);
    chk("std_din", (iss_q.size() > 0) ? 32'(iss_q[0]) : 32'hdead, {9'h058, 9'h0AA});
    chk("std_pc_final", 32'(pc), 2);

    // mvi at the top address wraps for the immediate and the pc
    rom[0] = 9'h048;
    rom[1] = 9'h1C0;
    rom[2] = 9'h011;
    rom[3] = 9'h022;
    rom[4] = 9'h0D3;
    rom[5] = 9'h104;
    rom[6] = 9'h18F;
    rom[7] = 9'h078;
    iss_q.delete();
    rd_q.delete();
    pulse_start();
    wait_for(0, 200, "wrap_reach_halt");
    exp_cnt = 13;
    chk("wrap_issues", 32'(iss_q.size()), 7);
    chk("wrap_last_din", (iss_q.size() > 0) ? 32'(iss_q[iss_q.size()-1]) : 32'hdead, {9'h078, 9'h048});
    n = rd_q.size();
    chk("wrap_rd_top", (n > 2) ? 32'(rd_q[n-3]) : 32'hdead, 7);
    chk("wrap_rd_imm", (n > 2) ? 32'(rd_q[n-2]) : 32'hdead, 0);
    chk("wrap_rd_next", (n > 2) ? 32'(rd_q[n-1]) : 32'hdead, 1);
    chk("wrap_pc", 32'(pc), 1);
    chk("wrap_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // reset in the middle of EXEC
    rom[0] = 9'b000_001_000;
    fixed_lat = -1;
    pulse_start();
    wait_for(2, 20, "rstx_issue");
    tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    exp_cnt = 0;
    chk("rstx_run", 32'(run), 0);
    chk("rstx_pc", 32'(pc), 0);
    chk("rstx_busy", 32'(busy), 0);
    chk("rstx_cnt", 32'(instr_cnt), 0);
    chk("rstx_err", 32'(err_timeout), 0);

    // randomized programs against an instruction-level model
    use_arr = 1'b1;
    spur_en = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 9'($urandom_range(0, 511));
      k = $urandom_range(1, 10);
      for (int j = 0; j < 64; j++) lats[j] = -1;
      for (int j = 0; j < k - 1; j++) lats[j] = $urandom_range(0, 4);

      exp_q.delete();
      p = 0;
      steps = 0;
      exp_halt = 1'b0;
      exp_err = 1'b0;
      while (!exp_halt && !exp_err) begin
        w = rom[p];
        if (w[8:6] == 3'b111) begin
          exp_halt = 1'b1;
        end else begin
          mvi = (w[8:6] == 3'b001);
          e = mvi ? rom[(p + 1) % DEPTH] : w;
          exp_q.push_back({w, e});
          if (lats[steps] < 0) begin
            exp_err = 1'b1;
          end else begin
            steps++;
            exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
            p = (p + (mvi ? 2 : 1)) % DEPTH;
          end
        end
      end

      issue_idx = 0;
      iss_q.delete();
      pulse_start();
      wait_for(5, 400, $sformatf("rnd%0d_end", r));
      chk($sformatf("rnd%0d_issues", r), 32'(iss_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        chk($sformatf("rnd%0d_iss%0d", r, i),
            (i < iss_q.size()) ? 32'(iss_q[i]) : 32'hdead, 32'(exp_q[i]));
      chk($sformatf("rnd%0d_pc", r), 32'(pc), 32'(p));
      chk($sformatf("rnd%0d_cnt", r), 32'(instr_cnt), 32'(exp_cnt));
      chk($sformatf("rnd%0d_halted", r), 32'(halted), 32'(exp_halt));
      chk($sformatf("rnd%0d_err", r), 32'(err_timeout), 32'(exp_err));
      chk($sformatf("rnd%0d_busy", r), 32'(busy), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
